// File: rtl/adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_capture_ctrl
//
// Capture controller sitting between the ADC deserialiser and the host-side
// CDC FIFO, clocked in the ADC data clock domain.  Packs NUM_CH channel
// samples into one FIFO word and supports continuous, fixed-length and
// level-triggered capture with decimation and overflow accounting.
//
// Ports:
//   clk             ADC data clock, all logic on the rising edge
//   reset           synchronous, active-high
//   arm             one-cycle pulse, starts a capture when idle
//   stop            one-cycle pulse, aborts any capture
//   mode            0=continuous, 1=fixed count, 2=level trigger + count,
//                   3=treated as 1
//   capture_len     FIFO words to write in modes 1/2
//   decim           keep one of every decim+1 qualified samples
//   trig_ch         channel compared in mode 2 (>= NUM_CH selects channel 0)
//   trig_level      signed trigger threshold
//   adc_ready       MMCM locked and IDELAY ready
//   data_valid      deserialiser frame aligned
//   adc_data        NUM_CH packed samples, channel 0 in the MSBs
//   fifo_prog_full  FIFO programmable-full flag
//   fifo_din        registered sample word presented to the FIFO
//   fifo_wr_en      FIFO write strobe
//   busy            high in WAIT_TRIG or CAPTURE
//   done            sticky completion flag, cleared by arm or reset
//   overflow_count  saturating count of kept samples dropped on prog_full
//   dbg_state       current FSM state (0=IDLE 1=WAIT_TRIG 2=CAPTURE 3=DONE)
//
// Handshake: the FIFO side is a plain write strobe.  fifo_din is valid in
// every cycle fifo_wr_en is high; there is no backpressure other than
// fifo_prog_full, which turns a kept sample into a counted drop.
// -----------------------------------------------------------------------------
module adc_capture_ctrl #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int LEN_W    = 24,
    parameter int DEC_W    = 8,
    parameter int OVF_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         stop,
    input  logic [1:0]                   mode,
    input  logic [LEN_W-1:0]             capture_len,
    input  logic [DEC_W-1:0]             decim,
    input  logic [1:0]                   trig_ch,
    input  logic [SAMPLE_W-1:0]          trig_level,
    input  logic                         adc_ready,
    input  logic                         data_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   adc_data,
    input  logic                         fifo_prog_full,
    output logic [NUM_CH*SAMPLE_W-1:0]   fifo_din,
    output logic                         fifo_wr_en,
    output logic                         busy,
    output logic                         done,
    output logic [OVF_W-1:0]             overflow_count,
    output logic [1:0]                   dbg_state
);

    localparam int DW = NUM_CH * SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state_q, state_d;

    // Configuration latched on arm acceptance
    logic [1:0]          mode_q;
    logic [LEN_W-1:0]    len_q;
    logic [DEC_W-1:0]    decim_q;
    logic [1:0]          trig_ch_q;
    logic [SAMPLE_W-1:0] level_q;

    logic [LEN_W-1:0]    word_q, word_d, word_inc;
    logic [DEC_W-1:0]    dec_q, dec_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic [DW-1:0]       din_q, din_d;
    logic                wr_q, wr_d;
    logic                done_q, done_d;
    logic [OVF_W-1:0]    ovf_q, ovf_d;
    logic                load_cfg;
    logic                keep;

    logic                acc;
    logic [SAMPLE_W-1:0] trig_sample;
    logic                crossing;

    assign acc = adc_ready & data_valid;

    // Channel 0 is the default so out-of-range trig_ch values fall back to it
    always_comb begin
        trig_sample = adc_data[DW-1 -: SAMPLE_W];
        for (int c = 1; c < NUM_CH; c++) begin
            if (trig_ch_q == 2'(c)) begin
                trig_sample = adc_data[DW-1-c*SAMPLE_W -: SAMPLE_W];
            end
        end
    end

    assign crossing = ($signed(prev_q) < $signed(level_q)) &&
                      ($signed(trig_sample) >= $signed(level_q));

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        dec_d      = dec_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        din_d      = din_q;
        wr_d       = 1'b0;
        done_d     = done_q;
        ovf_d      = ovf_q;
        load_cfg   = 1'b0;
        keep       = 1'b0;
        word_inc   = word_q + 1'b1;

        if (stop) begin
            // stop beats arm and drops the sample of this cycle
            if (state_q != IDLE) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        load_cfg   = 1'b1;
                        done_d     = 1'b0;
                        word_d     = '0;
                        dec_d      = '0;
                        ovf_d      = '0;
                        prev_vld_d = 1'b0;
                        state_d    = (mode == 2'd2) ? WAIT_TRIG : CAPTURE;
                    end
                end
                WAIT_TRIG: begin
                    if (acc) begin
                        prev_d     = trig_sample;
                        prev_vld_d = 1'b1;
                        // The first qualified sample after arm only primes prev
                        if (prev_vld_q && crossing) begin
                            state_d = CAPTURE;
                            if (len_q != '0) begin
                                // Triggering sample is the first kept one;
                                // decimation restarts from it
                                keep  = 1'b1;
                                dec_d = (decim_q == '0) ? '0 : DEC_W'(1);
                            end else begin
                                dec_d = '0;
                            end
                        end
                    end
                end
                CAPTURE: begin
                    if (mode_q != 2'd0 && len_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (acc) begin
                        keep  = (dec_q == '0);
                        dec_d = (dec_q == decim_q) ? '0 : dec_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (keep) begin
                if (fifo_prog_full) begin
                    if (ovf_q != '1) begin
                        ovf_d = ovf_q + 1'b1;
                    end
                end else begin
                    wr_d   = 1'b1;
                    din_d  = adc_data;
                    word_d = word_inc;
                    // Final write and entry to DONE share the same edge
                    if (mode_q != 2'd0 && word_inc == len_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            len_q      <= '0;
            decim_q    <= '0;
            trig_ch_q  <= '0;
            level_q    <= '0;
            word_q     <= '0;
            dec_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            dec_q      <= dec_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            din_q      <= din_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            if (load_cfg) begin
                mode_q    <= (mode == 2'd3) ? 2'd1 : mode;
                len_q     <= capture_len;
                decim_q   <= decim;
                trig_ch_q <= trig_ch;
                level_q   <= trig_level;
            end
        end
    end

    // Masking with reset keeps the strobe low for the whole reset cycle,
    // not just from the edge after it
    assign fifo_wr_en     = wr_q & ~reset;
    assign fifo_din       = din_q;
    assign busy           = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    assign done           = done_q;
    assign overflow_count = ovf_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_ctrl
//
// Self-checking bench for adc_capture_ctrl.  A second instance with a 3-bit
// overflow counter shares all inputs to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_adc_capture_ctrl;

    localparam int NUM_CH = 2;
    localparam int SW     = 16;
    localparam int LEN_W  = 24;
    localparam int DEC_W  = 8;
    localparam int OVF_W  = 16;
    localparam int DW     = NUM_CH * SW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              arm;
    logic              stop;
    logic [1:0]        mode;
    logic [LEN_W-1:0]  capture_len;
    logic [DEC_W-1:0]  decim;
    logic [1:0]        trig_ch;
    logic [SW-1:0]     trig_level;
    logic              adc_ready;
    logic              data_valid;
    logic [DW-1:0]     adc_data;
    logic              fifo_prog_full;

    logic [DW-1:0]     fifo_din;
    logic              fifo_wr_en;
    logic              busy;
    logic              done;
    logic [OVF_W-1:0]  overflow_count;
    logic [1:0]        dbg_state;

    logic [DW-1:0]     s_fifo_din;
    logic              s_fifo_wr_en;
    logic              s_busy;
    logic              s_done;
    logic [2:0]        s_overflow_count;
    logic [1:0]        s_dbg_state;

    adc_capture_ctrl #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .LEN_W(LEN_W), .DEC_W(DEC_W), .OVF_W(OVF_W)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
        .capture_len(capture_len), .decim(decim), .trig_ch(trig_ch),
        .trig_level(trig_level), .adc_ready(adc_ready), .data_valid(data_valid),
        .adc_data(adc_data), .fifo_prog_full(fifo_prog_full),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done),
        .overflow_count(overflow_count), .dbg_state(dbg_state)
    );

    adc_capture_ctrl #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .LEN_W(LEN_W), .DEC_W(DEC_W), .OVF_W(3)
    ) dut_small (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
        .capture_len(capture_len), .decim(decim), .trig_ch(trig_ch),
        .trig_level(trig_level), .adc_ready(adc_ready), .data_valid(data_valid),
        .adc_data(adc_data), .fifo_prog_full(fifo_prog_full),
        .fifo_din(s_fifo_din), .fifo_wr_en(s_fifo_wr_en), .busy(s_busy), .done(s_done),
        .overflow_count(s_overflow_count), .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Every FIFO write must match the oldest expected word
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got din 0x%0h want no write", fifo_din);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("write_data", fifo_din, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string name, input logic [DW-1:0] d);
        chk({name, "_wr_en"}, 32'(fifo_wr_en), 32'd1);
        exp_q.push_back(d);
    endtask

    task automatic expect_nowr(input string name);
        chk({name, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    endtask

    task automatic expect_st(input string name, input logic [1:0] st,
                             input logic b, input logic d);
        chk({name, "_state"}, 32'(dbg_state), 32'(st));
        chk({name, "_busy"},  32'(busy), 32'(b));
        chk({name, "_done"},  32'(done), 32'(d));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          arm;
        logic          vld;
        logic [1:0]    mode;
        logic [7:0]    len;
        logic [SW-1:0] lvl;
        logic [SW-1:0] ch1;
        logic          exp_wr;
        logic          exp_busy;
        logic          exp_done;
        logic [1:0]    exp_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic a, input logic v, input logic [1:0] m,
                                input logic [7:0] l, input logic [SW-1:0] lv,
                                input logic [SW-1:0] c1, input logic ew,
                                input logic eb, input logic ed, input logic [1:0] es);
        vec_t r;
        r.arm = a; r.vld = v; r.mode = m; r.len = l; r.lvl = lv; r.ch1 = c1;
        r.exp_wr = ew; r.exp_busy = eb; r.exp_done = ed; r.exp_st = es;
        return r;
    endfunction

    initial begin
        vec_t v;
        logic [DW-1:0] d;

        // Level trigger at +100 on ch1, 3 words.  First sample never triggers,
        // a non-qualified crossing is ignored, capture_len input changes
        // after arm are ignored.
        vecs.push_back(mk(1, 0, 2'd2, 8'd3, 16'd100, 16'd0,    0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 1, 2'd2, 8'd0, 16'd100, 16'd120,  0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 1, 2'd2, 8'd0, 16'd100, 16'hFFCE, 0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 1, 2'd2, 8'd0, 16'd100, 16'd90,   0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 0, 2'd2, 8'd0, 16'd100, 16'd120,  0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 1, 2'd2, 8'd0, 16'd100, 16'd120,  1, 1, 0, S_CAP));
        vecs.push_back(mk(0, 1, 2'd2, 8'd0, 16'd100, 16'd130,  1, 1, 0, S_CAP));
        vecs.push_back(mk(0, 1, 2'd2, 8'd0, 16'd100, 16'd80,   1, 0, 1, S_DONE));
        vecs.push_back(mk(0, 1, 2'd2, 8'd0, 16'd100, 16'd110,  0, 0, 1, S_IDLE));
        // Negative threshold -10, 1 word: signed crossing -30 -> 5,
        // triggering sample is also the final write
        vecs.push_back(mk(1, 0, 2'd2, 8'd1, 16'hFFF6, 16'd0,    0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 1, 2'd2, 8'd1, 16'hFFF6, 16'hFFEC, 0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 1, 2'd2, 8'd1, 16'hFFF6, 16'hFFE2, 0, 1, 0, S_WAIT));
        vecs.push_back(mk(0, 1, 2'd2, 8'd1, 16'hFFF6, 16'd5,    1, 0, 1, S_DONE));
        vecs.push_back(mk(0, 1, 2'd2, 8'd1, 16'hFFF6, 16'd40,   0, 0, 1, S_IDLE));

        // ---------- reset ----------
        reset = 1'b1; arm = 1'b0; stop = 1'b0; mode = 2'd0; capture_len = '0;
        decim = '0; trig_ch = 2'd1; trig_level = '0; adc_ready = 1'b1;
        data_valid = 1'b0; adc_data = '0; fifo_prog_full = 1'b0;
        repeat (3) cyc();
        expect_nowr("reset");
        chk("reset_din", fifo_din, 32'd0);
        chk("reset_ovf", 32'(overflow_count), 32'd0);
        expect_st("reset", S_IDLE, 0, 0);
        reset = 1'b0;
        cyc();
        expect_st("post_reset", S_IDLE, 0, 0);

        // ---------- mode 1, 8 words, decim 0, ramp, one pause ----------
        mode = 2'd1; capture_len = 24'd8; decim = 8'd0; arm = 1'b1;
        cyc();
        arm = 1'b0;
        expect_nowr("m1_arm");
        expect_st("m1_arm", S_CAP, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                data_valid = 1'b0;
                cyc();
                expect_nowr("m1_pause");
                chk("m1_pause_state", 32'(dbg_state), 32'(S_CAP));
            end
            data_valid = 1'b1;
            adc_data = {16'(i), 16'(i)};
            cyc();
            expect_wr($sformatf("m1_w%0d", i), {16'(i), 16'(i)});
            if (i < 7) chk($sformatf("m1_st%0d", i), 32'(dbg_state), 32'(S_CAP));
        end
        expect_st("m1_last", S_DONE, 0, 1);
        adc_data = {16'd8, 16'd8};
        cyc();
        expect_nowr("m1_after");
        expect_st("m1_after", S_IDLE, 0, 1);

        // ---------- mode 1, decim 3, 4 words ----------
        decim = 8'd3; capture_len = 24'd4; data_valid = 1'b0; arm = 1'b1;
        cyc();
        arm = 1'b0;
        expect_st("dec_arm", S_CAP, 1, 0);
        data_valid = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            adc_data = {16'(k), 16'(k)};
            cyc();
            if (k % 4 == 0) expect_wr($sformatf("dec_k%0d", k), {16'(k), 16'(k)});
            else expect_nowr($sformatf("dec_k%0d", k));
            chk($sformatf("dec_st%0d", k), 32'(dbg_state), 32'((k == 12) ? S_DONE : S_CAP));
        end
        adc_data = {16'd13, 16'd13};
        cyc();
        expect_nowr("dec_after");
        expect_st("dec_after", S_IDLE, 0, 1);

        // ---------- table-driven level-trigger vectors ----------
        decim = 8'd0; trig_ch = 2'd1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            arm = v.arm; mode = v.mode; capture_len = LEN_W'(v.len);
            trig_level = v.lvl; data_valid = v.vld;
            d = {16'(16'hA00 + i), v.ch1};
            adc_data = d;
            cyc();
            arm = 1'b0;
            if (v.exp_wr) expect_wr($sformatf("vec%0d", i), d);
            else expect_nowr($sformatf("vec%0d", i));
            expect_st($sformatf("vec%0d", i), v.exp_st, v.exp_busy, v.exp_done);
        end

        // ---------- mode 0, prog_full drops, saturation ----------
        mode = 2'd0; capture_len = 24'd2; data_valid = 1'b0; arm = 1'b1;
        cyc();
        arm = 1'b0;
        expect_st("m0_arm", S_CAP, 1, 0);
        data_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            adc_data = {16'(16'h100 + k), 16'(16'h200 + k)};
            cyc();
            expect_wr($sformatf("m0_w%0d", k), {16'(16'h100 + k), 16'(16'h200 + k)});
        end
        fifo_prog_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            adc_data = {16'(16'h300 + k), 16'(16'h300 + k)};
            // Arm while busy with a terminating config must be ignored
            if (k == 5) begin arm = 1'b1; mode = 2'd1; capture_len = '0; end
            cyc();
            arm = 1'b0;
            expect_nowr($sformatf("m0_drop%0d", k));
            if (k == 4) begin
                chk("ovf_5", 32'(overflow_count), 32'd5);
                chk("ovf_small_5", 32'(s_overflow_count), 32'd5);
            end
        end
        chk("ovf_9", 32'(overflow_count), 32'd9);
        chk("ovf_small_sat", 32'(s_overflow_count), 32'd7);
        expect_st("m0_busy", S_CAP, 1, 0);
        fifo_prog_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            adc_data = {16'(16'h400 + k), 16'(16'h400 + k)};
            cyc();
            expect_wr($sformatf("m0_resume%0d", k), {16'(16'h400 + k), 16'(16'h400 + k)});
        end

        // ---------- stop, then arm+stop, then arm ----------
        stop = 1'b1;
        adc_data = {16'h0BAD, 16'h0BAD};
        cyc();
        stop = 1'b0;
        expect_nowr("stop");
        expect_st("stop", S_IDLE, 0, 0);
        chk("stop_ovf_hold", 32'(overflow_count), 32'd9);
        cyc();
        expect_nowr("stop_idle");
        mode = 2'd0; arm = 1'b1; stop = 1'b1;
        cyc();
        arm = 1'b0; stop = 1'b0;
        expect_nowr("armstop");
        expect_st("armstop", S_IDLE, 0, 0);
        chk("armstop_ovf", 32'(overflow_count), 32'd9);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        expect_nowr("rearm");
        expect_st("rearm", S_CAP, 1, 0);
        chk("rearm_ovf", 32'(overflow_count), 32'd0);

        // ---------- reset mid-capture, data_valid toggling ----------
        adc_data = {16'h5A5A, 16'h0001};
        cyc();
        expect_wr("rst_a", {16'h5A5A, 16'h0001});
        data_valid = 1'b0;
        cyc();
        expect_nowr("rst_gap");
        data_valid = 1'b1;
        adc_data = {16'h5A5A, 16'h0002};
        cyc();
        expect_wr("rst_b", {16'h5A5A, 16'h0002});
        data_valid = 1'b0;
        cyc();
        expect_nowr("rst_gap2");
        reset = 1'b1; data_valid = 1'b1;
        adc_data = {16'h5A5A, 16'h0003};
        cyc();
        expect_nowr("rst_mid");
        chk("rst_mid_din", fifo_din, 32'd0);
        chk("rst_mid_ovf", 32'(overflow_count), 32'd0);
        expect_st("rst_mid", S_IDLE, 0, 0);
        data_valid = 1'b0;
        cyc();
        reset = 1'b0;
        expect_nowr("rst_hold");

        // ---------- capture_len 0, reserved mode 3 ----------
        mode = 2'd3; capture_len = '0; arm = 1'b1;
        cyc();
        arm = 1'b0;
        expect_st("len0_arm", S_CAP, 1, 0);
        data_valid = 1'b1;
        adc_data = {16'h7777, 16'h7777};
        cyc();
        expect_nowr("len0_done");
        expect_st("len0_done", S_DONE, 0, 1);
        cyc();
        expect_nowr("len0_idle");
        expect_st("len0_idle", S_IDLE, 0, 1);

        // ---------- final report ----------
        data_valid = 1'b0;
        repeat (3) cyc();
        chk("write_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Parametrised capture controller between the SYZYGY ADC deserialiser outputs and the host-side CDC FIFO, in the ADC data clock domain.
- Replaces the single-condition FIFO write gate: packs NUM_CH channels of SAMPLE_W bits into one FIFO word.
- Adds continuous, fixed-length and level-triggered capture modes, with decimation.
- Reports busy, done and overflow status for wire-out readback.

Parameters:
NUM_CH, 2, number of ADC channels presented on adc_data (1..4)
SAMPLE_W, 16, bits per channel sample (two's complement)
LEN_W, 24, width of capture length and sample counter
DEC_W, 8, width of decimation ratio
OVF_W, 16, width of saturating overflow counter

Ports:
clk  in  1  ADC data clock; all logic on rising edge
reset  in  1  synchronous, active-high
arm  in  1  single-cycle pulse; starts a capture (trigger-in bit)
stop  in  1  single-cycle pulse; aborts any capture
mode  in  2  0=continuous, 1=fixed count, 2=level trigger + count, 3=reserved (treated as 1)
capture_len  in  LEN_W  FIFO words to write in modes 1/2
decim  in  DEC_W  keep one of every decim+1 accepted samples
trig_ch  in  2  channel compared in mode 2 (values >= NUM_CH select channel 0)
trig_level  in  SAMPLE_W  signed threshold
adc_ready  in  1  MMCM locked AND IDELAY ready
data_valid  in  1  deserialiser frame-aligned / bitslip done
adc_data  in  NUM_CH*SAMPLE_W  channel 0 in MSBs
fifo_prog_full  in  1  FIFO programmable-full
fifo_din  out  NUM_CH*SAMPLE_W  registered adc_data
fifo_wr_en  out  1  FIFO write strobe
busy  out  1  state is WAIT_TRIG or CAPTURE
done  out  1  sticky; set on normal completion, cleared by arm or reset
overflow_count  out  OVF_W  samples dropped due to prog_full; saturates at all-ones

Behaviour:
- Reset: state IDLE; fifo_wr_en=0, fifo_din=0, busy=0, done=0, overflow_count=0; all counters and latched configuration cleared.
- Qualified sample: acc = adc_ready & data_valid in a given cycle.
- Configuration latching: mode, capture_len, decim, trig_ch and trig_level are latched on arm acceptance. Input changes during a capture have no effect.
- States:
  - IDLE: arm -> clear done, word count and decimation count, overflow_count; go to WAIT_TRIG in mode 2, else CAPTURE.
  - WAIT_TRIG: the trigger is a rising crossing between consecutive acc samples: prev < trig_level and cur >= trig_level, signed compare. The first acc sample after arm only loads prev and never triggers. On trigger -> CAPTURE; the triggering sample is the first kept sample, and the decimation counter restarts at it.
  - CAPTURE: the decimation counter counts acc cycles 0..decim and the sample is kept when it is 0. decim=0 keeps every acc sample.
    - Kept & !fifo_prog_full: next cycle fifo_wr_en=1 with fifo_din = that sample (latency 1), and word count increments.
    - Kept & fifo_prog_full: no write; overflow_count += 1, saturating.
    - Modes 1/2: when word count reaches capture_len on a write, go to DONE in the same cycle the final write is issued.
    - Mode 0: never terminates except by stop.
  - DONE: done=1 for one cycle of state, then IDLE with done held sticky.
- Boundary conditions:
  - capture_len=0 in modes 1/2: CAPTURE exits to DONE on the first cycle with zero writes. Mode 2 still waits for the trigger first.
  - stop in any non-IDLE state -> IDLE next cycle; done not set; no further writes after the stop cycle. A write already registered from the previous cycle still completes.
  - arm and stop in the same cycle: stop wins, state stays or goes IDLE.
  - arm while busy: ignored.
  - adc_ready or data_valid deasserting mid-capture pauses counting and writes; state is kept.
  - Word count wraps are impossible in modes 1/2. In mode 0 the count wraps modulo 2^LEN_W.
  - overflow_count holds its value until the next arm or reset.
- fifo_wr_en is never asserted in IDLE, in WAIT_TRIG, or while reset is high.

Test Plan:
- Mode 1, capture_len=8, decim=0, adc_data=ramp 0..: exactly 8 fifo_wr_en pulses with data 0..7, each one cycle after its sample; done=1; busy=0 afterwards.
- Mode 1, decim=3, capture_len=4, continuous acc: written samples are ramp values 0,4,8,12; then done.
- Mode 2, trig_ch=1, trig_level=100, ch1 sequence 50,90,120,130,80,110: the trigger fires on 120. With capture_len=3 the written ch1 values are 120,130,80; 110 is not written.
- Mode 0, fifo_prog_full high for 5 kept samples mid-stream: no writes during those samples; overflow_count=5; writes resume after deassert. With OVF_W=3, 9 drops -> overflow_count=7.
- Stop pulse during a mode-0 capture, then arm+stop in the same cycle: state IDLE, done=0, no writes after the stop cycle. A subsequent arm alone restarts and clears overflow_count.
- Synchronous reset asserted mid-CAPTURE with data_valid toggling: the next cycle shows all outputs 0 and state IDLE. Also, capture_len=0 in mode 1 gives done with zero writes.
